instruction_loader: RTL and testbench

- Writer side of the instruction-memory interface.
- Receives a byte stream containing a program image: header word count, payload words, checksum.
- Assembles the bytes into 32-bit instruction words and writes them into instruction memory at word-aligned byte addresses.
- Holds the processor in reset until a complete, checksum-verified image has been written. The fetch unit and instruction decoder then read the loaded program from BASE_ADDR.

---
 rtl/instruction_loader.sv | 189 ++++++++++++++++++
 tb/tb_instruction_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// instruction_loader: writer side of the instruction-memory interface.
// Consumes a byte stream {word count N, N payload words, checksum}, all words
// big-endian, writes the payload to instruction memory starting at BASE_ADDR
// and releases the processor hold only once the checksum has matched.
//
// Handshake: a byte transfers on a rising edge where InValid and InReady are
// both high; InReady depends only on the current state, never on InValid.
module instruction_loader #(
   parameter int          DEPTH     = 128,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [7:0]  InByte,
   input  logic        InValid,
   output logic        InReady,
   output logic [31:0] MemAddress,
   output logic [31:0] MemWriteData,
   output logic        MemWrite,
   output logic        CpuHold,
   output logic        Done,
   output logic        Error,
   output logic [31:0] WordsLoaded,
   output logic [2:0]  DbgState
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      LOAD = 3'd2,
      CHK  = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   state_t      state_q,      state_d;
   logic [1:0]  byte_cnt_q,   byte_cnt_d;
   logic [31:0] asm_q,        asm_d;
   logic [31:0] count_q,      count_d;
   logic [31:0] sum_q,        sum_d;
   logic [31:0] words_q,      words_d;
   logic [31:0] addr_q,       addr_d;
   logic [31:0] wdata_q,      wdata_d;
   logic        mem_write_q,  mem_write_d;
   logic        hold_q,       hold_d;
   logic        done_q,       done_d;
   logic        error_q,      error_d;

   logic        in_ready;
   logic        accept;
   logic        word_done;
   logic [31:0] word;

   // Byte acceptance and word assembly; the incoming byte lands in the LSB so
   // the first byte of a word ends up in bits [31:24].
   always_comb begin
      in_ready  = (state_q == HDR) || (state_q == LOAD) || (state_q == CHK);
      accept    = InValid && in_ready;
      word      = {asm_q[23:0], InByte};
      word_done = accept && (byte_cnt_q == 2'd3);
   end

   // Next-state and registered-output logic for the load sequence.
   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      asm_d       = asm_q;
      count_d     = count_q;
      sum_d       = sum_q;
      words_d     = words_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mem_write_d = 1'b0;
      hold_d      = hold_q;
      done_d      = done_q;
      error_d     = error_q;

      if (accept) begin
         byte_cnt_d = byte_cnt_q + 2'd1;
         asm_d      = word;
      end

      case (state_q)
         IDLE, DONE, ERR: begin
            if (Start) begin
               state_d    = HDR;
               hold_d     = 1'b1;
               done_d     = 1'b0;
               error_d    = 1'b0;
               words_d    = '0;
               sum_d      = '0;
               addr_d     = BASE_ADDR;
               byte_cnt_d = '0;
               asm_d      = '0;
            end
         end
         HDR: begin
            if (word_done) begin
               count_d = word;
               if (word > DEPTH_W) begin
                  state_d = ERR;
                  error_d = 1'b1;
               end else if (word == 32'd0) begin
                  state_d = CHK;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            // The write strobe is registered, so it appears the cycle after the
            // 4th byte while the next word keeps streaming in.
            if (word_done) begin
               mem_write_d = 1'b1;
               wdata_d     = word;
               addr_d      = BASE_ADDR + {words_q[29:0], 2'b00};
               words_d     = words_q + 32'd1;
               sum_d       = sum_q + word;
               if (words_q + 32'd1 == count_q) begin
                  state_d = CHK;
               end
            end
         end
         CHK: begin
            if (word_done) begin
               if (word == sum_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = ERR;
                  error_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         byte_cnt_q  <= '0;
         asm_q       <= '0;
         count_q     <= '0;
         sum_q       <= '0;
         words_q     <= '0;
         addr_q      <= BASE_ADDR;
         wdata_q     <= '0;
         mem_write_q <= 1'b0;
         hold_q      <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         asm_q       <= asm_d;
         count_q     <= count_d;
         sum_q       <= sum_d;
         words_q     <= words_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mem_write_q <= mem_write_d;
         hold_q      <= hold_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   // Output drive.
   always_comb begin
      InReady      = in_ready;
      MemAddress   = addr_q;
      MemWriteData = wdata_q;
      MemWrite     = mem_write_q;
      CpuHold      = hold_q;
      Done         = done_q;
      Error        = error_q;
      WordsLoaded  = words_q;
      DbgState     = state_q;
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: directed images, write and status scoreboards.
module tb_instruction_loader;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic [7:0]  InByte;
   logic        InValid;
   logic        InReady;
   logic [31:0] MemAddress;
   logic [31:0] MemWriteData;
   logic        MemWrite;
   logic        CpuHold;
   logic        Done;
   logic        Error;
   logic [31:0] WordsLoaded;
   logic [2:0]  DbgState;

   int n_cmp = 0;
   int n_err = 0;
   int wr_count = 0;

   logic [63:0] exp_wr_q[$];   // {address, data}
   logic [34:0] exp_st_q[$];   // {Done, Error, CpuHold, WordsLoaded}

   instruction_loader #(.DEPTH(128), .BASE_ADDR(32'h0000_0000)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .InByte(InByte),
      .InValid(InValid), .InReady(InReady), .MemAddress(MemAddress),
      .MemWriteData(MemWriteData), .MemWrite(MemWrite), .CpuHold(CpuHold),
      .Done(Done), .Error(Error), .WordsLoaded(WordsLoaded), .DbgState(DbgState)
   );

   // Clock and watchdog.
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #400000;
      $display("FAIL watchdog: run did not complete, got timeout, required finish");
      $fatal(1, "watchdog");
   end

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: pops write and status expectations when the DUT presents them.
   logic prev_done = 1'b0;
   logic prev_err  = 1'b0;
   initial begin
      forever begin
         @(negedge Clk);
         if (MemWrite === 1'b1) begin
            wr_count++;
            if (exp_wr_q.size() == 0) begin
               check("unexpected_write", {MemAddress, MemWriteData}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               check("write", {MemAddress, MemWriteData}, exp_wr_q.pop_front());
            end
         end
         if ((Done && !prev_done) || (Error && !prev_err)) begin
            if (exp_st_q.size() == 0) begin
               check("unexpected_status", {29'd0, Done, Error, CpuHold, WordsLoaded}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               check("status", {29'd0, Done, Error, CpuHold, WordsLoaded}, {29'd0, exp_st_q.pop_front()});
            end
         end
         prev_done = Done;
         prev_err  = Error;
      end
   end

   // Driver tasks.
   task automatic do_reset(input bit with_start);
      Reset = 1'b1; Start = with_start; InValid = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b0; Start = 1'b0;
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int max_gap, input bit start_too);
      int ngap;
      int guard;
      bit rdy;
      ngap = $urandom_range(0, max_gap);
      InValid = 1'b0;
      repeat (ngap) begin @(posedge Clk); #1; end
      InByte = b; InValid = 1'b1; Start = start_too;
      guard = 0;
      rdy = 1'b0;
      do begin
         @(negedge Clk);
         rdy = InReady;
         @(posedge Clk); #1;
         Start = 1'b0;
         guard++;
      end while (!rdy && guard < 50);
      InValid = 1'b0;
      if (!rdy) check("handshake_timeout", 64'(rdy), 64'd1);
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap, input int start_at);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[31 - 8*i -: 8], max_gap, start_at == i);
      end
   endtask

   task automatic wait_end();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge Clk);
         if (Done || Error) seen = 1'b1;
      end
      if (!seen) check("end_timeout", 64'(seen), 64'd1);
      @(posedge Clk); #1;
   endtask

   task automatic check_drained(input string name, input int writes_before, input int writes_exp);
      check({name, "_wr_left"}, 64'(exp_wr_q.size()), 64'd0);
      check({name, "_st_left"}, 64'(exp_st_q.size()), 64'd0);
      check({name, "_wr_count"}, 64'(wr_count - writes_before), 64'(writes_exp));
   endtask

   // Stimulus.
   initial begin
      int w0;
      Reset = 1'b0; Start = 1'b0; InByte = 8'h00; InValid = 1'b0;
      @(posedge Clk); #1;
      do_reset(1'b0);
      @(negedge Clk);
      check("rst_state", 64'(DbgState), 64'd0);
      check("rst_ready", 64'(InReady), 64'd0);
      check("rst_outs", {MemAddress, MemWriteData}, 64'd0);
      check("rst_flags", {60'd0, MemWrite, CpuHold, Done, Error}, 64'b0100);
      check("rst_words", 64'(WordsLoaded), 64'd0);
      @(posedge Clk); #1;

      // Good two-word image.
      w0 = wr_count;
      exp_wr_q.push_back({32'h0, 32'h2408_0005});
      exp_wr_q.push_back({32'h4, 32'h2409_000A});
      exp_st_q.push_back({1'b1, 1'b0, 1'b0, 32'd2});
      pulse_start();
      send_word(32'h0000_0002, 0, -1);
      send_word(32'h2408_0005, 0, -1);
      send_word(32'h2409_000A, 0, -1);
      send_word(32'h4811_000F, 0, -1);
      wait_end();
      check_drained("good2", w0, 2);
      check("good2_ready", {62'd0, InReady, MemWrite}, 64'd0);

      // Bad checksum, started straight from DONE.
      w0 = wr_count;
      exp_wr_q.push_back({32'h0, 32'h2408_0005});
      exp_wr_q.push_back({32'h4, 32'h2409_000A});
      exp_st_q.push_back({1'b0, 1'b1, 1'b1, 32'd2});
      pulse_start();
      check("start_clears", {61'd0, Done, Error, CpuHold}, 64'b001);
      send_word(32'h0000_0002, 0, -1);
      send_word(32'h2408_0005, 0, -1);
      send_word(32'h2409_000A, 0, -1);
      send_word(32'h4811_000E, 0, -1);
      wait_end();
      check_drained("badsum", w0, 2);

      // Header above DEPTH: error right after the 4th header byte.
      w0 = wr_count;
      exp_st_q.push_back({1'b0, 1'b1, 1'b1, 32'd0});
      pulse_start();
      send_word(32'h0000_0081, 0, -1);
      @(negedge Clk);
      check("ovf_error_now", 64'(Error), 64'd1);
      check("ovf_ready", 64'(InReady), 64'd0);
      @(posedge Clk); #1;
      repeat (3) begin @(posedge Clk); #1; end
      check_drained("ovf", w0, 0);

      // Empty image, good and bad checksum.
      w0 = wr_count;
      exp_st_q.push_back({1'b1, 1'b0, 1'b0, 32'd0});
      pulse_start();
      send_word(32'h0000_0000, 0, -1);
      send_word(32'h0000_0000, 0, -1);
      wait_end();
      check_drained("empty_ok", w0, 0);
      exp_st_q.push_back({1'b0, 1'b1, 1'b1, 32'd0});
      pulse_start();
      send_word(32'h0000_0000, 0, -1);
      send_word(32'h0000_0001, 0, -1);
      wait_end();
      check_drained("empty_bad", w0, 0);

      // Three words with random InValid gaps and a Start pulse inside LOAD;
      // checksum wraps: 1 + 2 + FFFFFFFF = 2.
      w0 = wr_count;
      exp_wr_q.push_back({32'h0, 32'h0000_0001});
      exp_wr_q.push_back({32'h4, 32'h0000_0002});
      exp_wr_q.push_back({32'h8, 32'hFFFF_FFFF});
      exp_st_q.push_back({1'b1, 1'b0, 1'b0, 32'd3});
      pulse_start();
      send_word(32'h0000_0003, 3, -1);
      send_word(32'h0000_0001, 3, -1);
      send_word(32'h0000_0002, 3, 2);
      send_word(32'hFFFF_FFFF, 3, -1);
      send_word(32'h0000_0002, 3, -1);
      wait_end();
      check_drained("gaps", w0, 3);

      // Reset after 6 payload bytes, then a full reload from BASE_ADDR.
      w0 = wr_count;
      exp_wr_q.push_back({32'h0, 32'hDEAD_BEEF});
      pulse_start();
      send_word(32'h0000_0003, 0, -1);
      send_word(32'hDEAD_BEEF, 0, -1);
      send_byte(8'h11, 0, 1'b0);
      send_byte(8'h22, 0, 1'b0);
      do_reset(1'b0);
      @(negedge Clk);
      check("midrst_state", 64'(DbgState), 64'd0);
      check("midrst_flags", {61'd0, CpuHold, Done, Error}, 64'b100);
      check("midrst_words", 64'(WordsLoaded), 64'd0);
      @(posedge Clk); #1;
      check_drained("midrst", w0, 1);
      w0 = wr_count;
      exp_wr_q.push_back({32'h0, 32'hA000_0000});
      exp_wr_q.push_back({32'h4, 32'h6000_0001});
      exp_wr_q.push_back({32'h8, 32'h1234_5678});
      exp_st_q.push_back({1'b1, 1'b0, 1'b0, 32'd3});
      pulse_start();
      send_word(32'h0000_0003, 0, -1);
      send_word(32'hA000_0000, 0, -1);
      send_word(32'h6000_0001, 0, -1);
      send_word(32'h1234_5678, 0, -1);
      send_word(32'h1234_5679, 0, -1);
      wait_end();
      check_drained("reload", w0, 3);

      // Reset and Start together: Reset wins.
      do_reset(1'b1);
      @(negedge Clk);
      check("rst_start_state", 64'(DbgState), 64'd0);
      check("rst_start_ready", 64'(InReady), 64'd0);
      @(posedge Clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
